// File: rtl/rr_arbiter_node.sv
// N-input round-robin arbiter node with upstream request/grant chaining.
// Optional ownership locking is compiled in when ARB_LOCK_EN is defined.
module rr_arbiter_node #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               arb_req,
  input  logic               arb_grant
);

  // Vectors padded to a power of two so any IDX_W-bit index is in range.
  localparam int unsigned      PadW    = 2 ** IDX_W;
  localparam logic [IDX_W:0]   NumReqW = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 1 || LOCK_MAX < 1) begin : g_bad_cfg
    $error("rr_arbiter_node: NUM_REQ and LOCK_MAX must be >= 1");
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + IDX_W'(1);
  endfunction

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [PadW-1:0]  req_pad;
  logic [PadW-1:0]  grant_pad;
  logic [IDX_W:0]   scan_sum;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [IDX_W-1:0] grant_sel;
  logic             grant_en;

`ifdef ARB_LOCK_EN
  localparam int unsigned     CntW     = $clog2(LOCK_MAX + 1);
  localparam logic [CntW-1:0] LockMaxC = CntW'(LOCK_MAX);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [PadW-1:0]  lock_pad;

  always_comb begin
    lock_pad = '0;
    lock_pad[NUM_REQ-1:0] = lock;
  end

  assign cnt_inc = cnt_q + CntW'(1);
`endif

  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
  end

  // Rotating scan starting at ptr; first hit is the winner.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_sum = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_sum = {1'b0, ptr_q} + (IDX_W + 1)'(off);
      if (scan_sum >= NumReqW) begin
        scan_sum = scan_sum - NumReqW;
      end
      if (!found && req_pad[scan_sum[IDX_W-1:0]]) begin
        winner = scan_sum[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_sel = winner;
    grant_en  = 1'b0;
    arb_req   = 1'b0;
    ptr_d     = ptr_q;
`ifdef ARB_LOCK_EN
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    if (state_q == StLocked) begin
      grant_sel = owner_q;
      arb_req   = req_pad[owner_q];
      // A stalled upstream freezes the lock entirely, including release.
      if (arb_grant) begin
        if (req_pad[owner_q]) begin
          grant_en = 1'b1;
          cnt_d    = cnt_inc;
        end
        if (!req_pad[owner_q] || !lock_pad[owner_q] || cnt_inc == LockMaxC) begin
          state_d = StIdle;
          ptr_d   = next_idx(owner_q);
          cnt_d   = '0;
        end
      end
    end else
`endif
    begin
      arb_req = |req;
      if (arb_grant && arb_req) begin
        grant_en = 1'b1;
`ifdef ARB_LOCK_EN
        // With LOCK_MAX==1 the first grant already exhausts the lock.
        if (lock_pad[winner] && LOCK_MAX > 1) begin
          state_d = StLocked;
          owner_d = winner;
          cnt_d   = CntW'(1);
        end else
`endif
        begin
          ptr_d = next_idx(winner);
        end
      end
    end
    if (rst) begin
      grant_en = 1'b0;
      arb_req  = 1'b0;
    end
  end

  always_comb begin
    grant_pad = '0;
    if (grant_en) begin
      grant_pad[grant_sel] = 1'b1;
    end
  end

  assign grant       = grant_pad[NUM_REQ-1:0];
  assign grant_valid = grant_en;
  assign grant_idx   = grant_en ? grant_sel : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
`ifdef ARB_LOCK_EN
      state_q <= StIdle;
      owner_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      ptr_q   <= ptr_d;
`ifdef ARB_LOCK_EN
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter_node.sv
// Bench for rr_arbiter_node: directed vector table, then random traffic against a
// round-robin reference model; also checks a single-requester instance.
module tb_rr_arbiter_node;

  localparam int unsigned N       = 4;
  localparam int unsigned LockMax = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic         arb_grant;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic         arb_req;

  logic [0:0]   req1;
  logic [0:0]   grant1;
  logic         grant_valid1;
  logic [0:0]   grant_idx1;
  logic         arb_req1;
`ifdef ARB_LOCK_EN
  logic [0:0]   lock1;
`endif

  always #5 clk = ~clk;

  rr_arbiter_node #(
    .NUM_REQ (N),
    .LOCK_MAX(LockMax)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
`ifdef ARB_LOCK_EN
    .lock       (lock),
`endif
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .arb_req    (arb_req),
    .arb_grant  (arb_grant)
  );

  rr_arbiter_node #(
    .NUM_REQ (1),
    .LOCK_MAX(LockMax)
  ) u_one (
    .clk        (clk),
    .rst        (rst),
    .req        (req1),
`ifdef ARB_LOCK_EN
    .lock       (lock1),
`endif
    .grant      (grant1),
    .grant_valid(grant_valid1),
    .grant_idx  (grant_idx1),
    .arb_req    (arb_req1),
    .arb_grant  (arb_grant)
  );

  typedef struct {
    logic         r;
    logic [N-1:0] rq;
    logic         ag;
    logic [N-1:0] lk;
    logic [N-1:0] eg;
    logic         ea;
    string        nm;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int m_ptr;
  bit m_locked;
  int m_owner;
  int m_cnt;

  function automatic void add(input logic r, input logic [N-1:0] rq, input logic ag,
                              input logic [N-1:0] lk, input logic [N-1:0] eg,
                              input logic ea, input string nm);
    vecs.push_back('{r, rq, ag, lk, eg, ea, nm});
  endfunction

  function automatic int rr_winner(input logic [N-1:0] rq);
    for (int k = 0; k < N; k++) begin
      if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_grant(input logic r, input logic [N-1:0] rq,
                                               input logic ag);
    logic [N-1:0] g;
    int w;
    g = '0;
    if (r || !ag) return g;
    if (m_locked) begin
      if (rq[m_owner]) g[m_owner] = 1'b1;
    end else begin
      w = rr_winner(rq);
      if (w >= 0) g[w] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic model_arb_req(input logic r, input logic [N-1:0] rq);
    if (r) return 1'b0;
    return m_locked ? rq[m_owner] : (rq != '0);
  endfunction

  function automatic void model_release();
    m_locked = 1'b0;
    m_ptr    = (m_owner + 1) % N;
    m_cnt    = 0;
  endfunction

  function automatic void model_update(input logic r, input logic [N-1:0] rq, input logic ag,
                                       input logic [N-1:0] lk);
    int w;
    if (r) begin
      m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_cnt = 0;
    end else if (ag) begin
      if (m_locked) begin
        if (!rq[m_owner]) begin
          model_release();
        end else begin
          m_cnt++;
          if (!lk[m_owner] || m_cnt >= LockMax) model_release();
        end
      end else begin
        w = rr_winner(rq);
        if (w >= 0) begin
          if (lk[w] && LockMax > 1) begin
            m_locked = 1'b1; m_owner = w; m_cnt = 1;
          end else begin
            m_ptr = (w + 1) % N;
          end
        end
      end
    end
  endfunction

  task automatic step(input logic r, input logic [N-1:0] rq, input logic ag,
                      input logic [N-1:0] lk, input logic [N-1:0] eg, input logic ea,
                      input string nm);
    int  e_idx;
    logic e1;
    rst       = r;
    req       = rq;
    arb_grant = ag;
    lock      = lk;
    req1      = rq[0:0];
`ifdef ARB_LOCK_EN
    lock1     = lk[0:0];
`endif
    @(negedge clk);
    e_idx = 0;
    for (int i = 0; i < N; i++) if (eg[i]) e_idx = i;
    n_vec++;
    if (grant !== eg || grant_valid !== (eg != '0) || int'(grant_idx) != e_idx ||
        arb_req !== ea) begin
      n_err++;
      $display("FAIL %s: grant=%b valid=%b idx=%0d arb_req=%b, expected grant=%b valid=%b idx=%0d arb_req=%b",
               nm, grant, grant_valid, grant_idx, arb_req, eg, (eg != '0), e_idx, ea);
    end
    e1 = rq[0] & ag & ~r;
    n_vec++;
    if (grant1 !== e1 || grant_valid1 !== e1 || grant_idx1 !== 1'b0 ||
        arb_req1 !== (rq[0] & ~r)) begin
      n_err++;
      $display("FAIL %s/one: grant=%b valid=%b idx=%b arb_req=%b, expected grant=%b arb_req=%b",
               nm, grant1, grant_valid1, grant_idx1, arb_req1, e1, rq[0] & ~r);
    end
    @(posedge clk);
    model_update(r, rq, ag, lk);
    #1;
  endtask

  initial begin
    logic [N-1:0] rq, lk, eg;
    logic r, ag, ea;

    rst = 1'b1; req = '0; arb_grant = 1'b1; lock = '0; req1 = '0;
`ifdef ARB_LOCK_EN
    lock1 = '0;
`endif
    m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_cnt = 0;

    add(1, 4'b0000, 1, 4'b0000, 4'b0000, 0, "reset_idle");
    add(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, "reset_req");
    for (int i = 0; i < 8; i++) add(0, 4'b1111, 1, 4'b0000, 4'b0001 << (i % 4), 1, "rr_all");
    for (int i = 0; i < 4; i++) add(0, 4'b1010, 1, 4'b0000, (i % 2) ? 4'b1000 : 4'b0010, 1, "rr_1010");
    add(0, 4'b1111, 1, 4'b0000, 4'b0001, 1, "stall_pre");
    for (int i = 0; i < 3; i++) add(0, 4'b1111, 0, 4'b0000, 4'b0000, 1, "stall");
    add(0, 4'b1111, 1, 4'b0000, 4'b0010, 1, "stall_post");
    add(0, 4'b0100, 0, 4'b0000, 4'b0000, 1, "chg_stall");
    add(0, 4'b0001, 1, 4'b0000, 4'b0001, 1, "chg_post");
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, "no_req");
    add(0, 4'b1111, 1, 4'b0000, 4'b0010, 1, "pre_reset");
    add(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, "mid_reset");
    add(0, 4'b1111, 1, 4'b0000, 4'b0001, 1, "post_reset0");
    add(0, 4'b1111, 1, 4'b0000, 4'b0010, 1, "post_reset1");
    add(0, 4'b1000, 1, 4'b0000, 4'b1000, 1, "wrap0");
    add(0, 4'b1001, 1, 4'b0000, 4'b0001, 1, "wrap1");
    add(0, 4'b1001, 1, 4'b0000, 4'b1000, 1, "wrap2");
`ifdef ARB_LOCK_EN
    add(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, "lk_reset");
    for (int i = 0; i < 3; i++) add(0, 4'b1111, 1, 4'b0001, 4'b0001, 1, "lk_hold");
    add(0, 4'b1111, 1, 4'b0000, 4'b0001, 1, "lk_release");
    add(0, 4'b1111, 1, 4'b0000, 4'b0010, 1, "lk_after");
    add(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, "lkmax_reset");
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 1, 4'b0001, 4'b0001, 1, "lkmax_hold");
    add(0, 4'b1111, 1, 4'b0001, 4'b0010, 1, "lkmax_forced");
    add(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, "lkp_reset");
    add(0, 4'b0001, 1, 4'b0001, 4'b0001, 1, "lkp_enter");
    add(0, 4'b1111, 0, 4'b0001, 4'b0000, 1, "lkp_pause");
    for (int i = 0; i < 3; i++) add(0, 4'b1111, 1, 4'b0001, 4'b0001, 1, "lkp_hold");
    add(0, 4'b1111, 1, 4'b0001, 4'b0010, 1, "lkp_forced");
    add(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, "lkd_reset");
    add(0, 4'b1111, 1, 4'b0001, 4'b0001, 1, "lkd_enter");
    add(0, 4'b1110, 1, 4'b0001, 4'b0000, 0, "lkd_drop");
    add(0, 4'b1110, 1, 4'b0000, 4'b0010, 1, "lkd_after");
`endif

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].rq, vecs[i].ag, vecs[i].lk, vecs[i].eg, vecs[i].ea, vecs[i].nm);
    end

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      rq = N'($urandom);
      ag = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
      lk = N'($urandom) & N'($urandom);
`else
      lk = '0;
`endif
      eg = model_grant(r, rq, ag);
      ea = model_arb_req(r, rq);
      step(r, rq, ag, lk, eg, ea, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
